// File: rtl/fpu_mant_mul_iter.sv
// Iterative mantissa multiplier: CDigBits multiplier bits retired per enabled clock.
// Optional round-to-nearest-even of the returned top bits via macro FPU_MUL_RNE_EN.
module fpu_mant_mul_iter #(
    parameter int CMantLen = 28,
    parameter int CDigBits = 4
) (
    input  logic                AClkH,
    input  logic                AResetHN,
    input  logic                AClkHEn,
    input  logic [CMantLen-1:0] ADataS,
    input  logic [CMantLen-1:0] ADataD,
    input  logic                AStart,
    output logic [CMantLen+1:0] ADataR,
    output logic                ASticky,
    output logic                ABusy,
    output logic                AWrEn
);

    localparam int CSteps = CMantLen / CDigBits;
    localparam int CCntW  = (CSteps > 1) ? $clog2(CSteps) : 1;
    localparam int CAccW  = 2 * CMantLen;
    localparam int CResW  = CMantLen + 2;

    generate
        if ((CMantLen % CDigBits) != 0) begin : g_bad_cfg
            $error("CMantLen must be a multiple of CDigBits");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CCntW-1:0]   cnt;
    logic [CAccW-1:0]   acc;
    logic [CAccW-1:0]   acc_nxt;
    logic [CAccW-1:0]   pp;
    logic [CMantLen-1:0] ops;
    logic [CMantLen-1:0] opd;
    logic               last;
    logic               load;
    logic [CResW-1:0]   res;

    assign last = (cnt == CCntW'(CSteps - 1));

    // Partial product of the low multiplier digit, aligned to its weight.
    always_comb begin
        pp      = CAccW'(ops) * CAccW'(opd[CDigBits-1:0]);
        acc_nxt = acc + (pp << (cnt * CDigBits));
    end

    // State register.
    always_ff @(posedge AClkH or negedge AResetHN) begin
        if (!AResetHN) begin
            state <= IDLE;
        end else if (AClkHEn) begin
            state <= state_nxt;
        end
    end

    // Next-state, operand load strobe and handshake outputs.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        ABusy     = 1'b0;
        AWrEn     = 1'b0;
        unique case (state)
            IDLE: begin
                if (AStart) begin
                    load      = 1'b1;
                    state_nxt = MUL;
                end
            end
            MUL: begin
                ABusy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ABusy = 1'b1;
                AWrEn = 1'b1;
                if (AStart) begin
                    load      = 1'b1;
                    state_nxt = MUL;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture and shift-add accumulation.
    always_ff @(posedge AClkH or negedge AResetHN) begin
        if (!AResetHN) begin
            ops <= '0;
            opd <= '0;
            acc <= '0;
            cnt <= '0;
        end else if (AClkHEn) begin
            if (load) begin
                ops <= ADataS;
                opd <= ADataD;
                acc <= '0;
                cnt <= '0;
            end else if (state == MUL) begin
                acc <= acc_nxt;
                opd <= opd >> CDigBits;
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef FPU_MUL_RNE_EN
    logic [CResW-1:0] rnd_q;
    logic [CResW-1:0] trn_nxt;
    logic             grd_nxt;
    logic             stk_nxt;

    // Round the final accumulator value; the max truncated value cannot carry out.
    always_comb begin
        trn_nxt = acc_nxt[CAccW-1:CMantLen-2];
        grd_nxt = acc_nxt[CMantLen-3];
        stk_nxt = |acc_nxt[CMantLen-4:0];
    end

    // Register the rounded result on the edge that enters DONE.
    always_ff @(posedge AClkH or negedge AResetHN) begin
        if (!AResetHN) begin
            rnd_q <= '0;
        end else if (AClkHEn && state == MUL && last) begin
            rnd_q <= trn_nxt + CResW'(grd_nxt & (stk_nxt | trn_nxt[0]));
        end
    end

    assign res = rnd_q;
`else
    assign res = acc[CAccW-1:CMantLen-2];
`endif

    // Result outputs are forced to zero outside the valid pulse.
    always_comb begin
        ADataR  = AWrEn ? res : '0;
        ASticky = AWrEn & (|acc[CMantLen-3:0]);
    end

endmodule

// File: tb/tb_fpu_mant_mul_iter.sv
// Directed bench for fpu_mant_mul_iter (CMantLen=28, CDigBits=4).
// Expected values are hand-computed; rounding-mode values follow FPU_MUL_RNE_EN.
module tb_fpu_mant_mul_iter;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [27:0] sa;
    logic [27:0] da;
    logic        start;
    logic [29:0] datar;
    logic        sticky;
    logic        busy;
    logic        wren;

    int tests;
    int fails;

    fpu_mant_mul_iter #(
        .CMantLen(28),
        .CDigBits(4)
    ) dut (
        .AClkH   (clk),
        .AResetHN(rst_n),
        .AClkHEn (en),
        .ADataS  (sa),
        .ADataD  (da),
        .AStart  (start),
        .ADataR  (datar),
        .ASticky (sticky),
        .ABusy   (busy),
        .AWrEn   (wren)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Start one operation and wait (bounded) for the result pulse.
    task automatic do_op(input logic [27:0] s, input logic [27:0] d,
                         output logic [29:0] r, output logic st,
                         output int edges);
        @(negedge clk);
        sa    = s;
        da    = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 1;
        while (!wren && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        r  = datar;
        st = sticky;
    endtask

    task automatic test_reset;
        #1;
        tests++;
        if (datar !== 30'd0) begin
            fails++;
            $display("FAIL rst_datar got %h want 0", datar);
        end
        tests++;
        if (sticky !== 1'b0 || busy !== 1'b0 || wren !== 1'b0) begin
            fails++;
            $display("FAIL rst_flags got st=%b busy=%b wr=%b want 0",
                     sticky, busy, wren);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vectors;
        logic [27:0] vs [7];
        logic [27:0] vd [7];
        logic [29:0] vr [7];
        logic        vst[7];
        logic [29:0] r;
        logic        st;
        int          edges;
        vs[0] = 28'hFFFFFFF; vd[0] = 28'hFFFFFFF; vr[0] = 30'h3FFFFFF8; vst[0] = 1;
        vs[1] = 28'h8000000; vd[1] = 28'h8000000; vr[1] = 30'h10000000; vst[1] = 0;
`ifdef FPU_MUL_RNE_EN
        vs[2] = 28'd3;       vd[2] = 28'h2000000; vr[2] = 30'd2;        vst[2] = 1;
        vs[3] = 28'd1;       vd[3] = 28'h2000000; vr[3] = 30'd0;        vst[3] = 1;
        vs[4] = 28'hFFFFFFF; vd[4] = 28'd1;       vr[4] = 30'd4;        vst[4] = 1;
`else
        vs[2] = 28'd3;       vd[2] = 28'h2000000; vr[2] = 30'd1;        vst[2] = 1;
        vs[3] = 28'd1;       vd[3] = 28'h2000000; vr[3] = 30'd0;        vst[3] = 1;
        vs[4] = 28'hFFFFFFF; vd[4] = 28'd1;       vr[4] = 30'd3;        vst[4] = 1;
`endif
        vs[5] = 28'h4000000; vd[5] = 28'd5;       vr[5] = 30'd5;        vst[5] = 0;
        vs[6] = 28'd0;       vd[6] = 28'h1234567; vr[6] = 30'd0;        vst[6] = 0;
        for (int i = 0; i < 7; i++) begin
            do_op(vs[i], vd[i], r, st, edges);
            tests++;
            if (edges !== 8) begin
                fails++;
                $display("FAIL vec%0d_latency got %0d want 8", i, edges);
            end
            tests++;
            if (r !== vr[i] || st !== vst[i]) begin
                fails++;
                $display("FAIL vec%0d_result got %h/%b want %h/%b",
                         i, r, st, vr[i], vst[i]);
            end
            tests++;
            if (busy !== 1'b1) begin
                fails++;
                $display("FAIL vec%0d_busy_done got %b want 1", i, busy);
            end
            @(negedge clk);
            tests++;
            if (wren !== 1'b0 || datar !== 30'd0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL vec%0d_idle got wr=%b r=%h busy=%b want 0",
                         i, wren, datar, busy);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [29:0] r;
        logic        st;
        int          edges;
        int          gap;
        do_op(28'h8000000, 28'h8000000, r, st, edges);
        sa    = 28'hFFFFFFF;
        da    = 28'hFFFFFFF;
        start = 1'b1;
        tests++;
        if (r !== 30'h10000000 || st !== 1'b0 || edges !== 8) begin
            fails++;
            $display("FAIL b2b_first got %h/%b/%0d want 10000000/0/8",
                     r, st, edges);
        end
        @(negedge clk);
        start = 1'b0;
        gap   = 1;
        while (!wren && gap < 40) begin
            @(negedge clk);
            gap++;
        end
        tests++;
        if (gap !== 8) begin
            fails++;
            $display("FAIL b2b_gap got %0d want 8", gap);
        end
        tests++;
        if (datar !== 30'h3FFFFFF8 || sticky !== 1'b1) begin
            fails++;
            $display("FAIL b2b_second got %h/%b want 3FFFFFF8/1",
                     datar, sticky);
        end
        @(negedge clk);
    endtask

    task automatic test_start_mid_mul;
        int edges;
        @(negedge clk);
        sa    = 28'h4000000;
        da    = 28'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        sa    = 28'hFFFFFFF;
        da    = 28'hFFFFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 4;
        while (!wren && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        tests++;
        if (edges !== 8 || datar !== 30'd5 || sticky !== 1'b0) begin
            fails++;
            $display("FAIL midstart_result got %h/%b/%0d want 5/0/8",
                     datar, sticky, edges);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || wren !== 1'b0) begin
            fails++;
            $display("FAIL midstart_idle got busy=%b wr=%b want 0",
                     busy, wren);
        end
    endtask

    task automatic test_clock_enable;
        int   edges;
        int   iters;
        logic e;
        @(negedge clk);
        en    = 1'b1;
        sa    = 28'hFFFFFFF;
        da    = 28'hFFFFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 1;
        iters = 0;
        while (!wren && iters < 300) begin
            e  = 1'($urandom_range(0, 1));
            en = e;
            @(negedge clk);
            if (e) edges++;
            iters++;
        end
        tests++;
        if (edges !== 8) begin
            fails++;
            $display("FAIL clken_latency got %0d want 8", edges);
        end
        tests++;
        if (datar !== 30'h3FFFFFF8 || sticky !== 1'b1) begin
            fails++;
            $display("FAIL clken_result got %h/%b want 3FFFFFF8/1",
                     datar, sticky);
        end
        en = 1'b0;
        @(negedge clk);
        tests++;
        if (wren !== 1'b1 || datar !== 30'h3FFFFFF8) begin
            fails++;
            $display("FAIL clken_hold got wr=%b r=%h want 1/3FFFFFF8",
                     wren, datar);
        end
        en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op;
        logic [29:0] r;
        logic        st;
        int          edges;
        logic        seen;
        @(negedge clk);
        sa    = 28'hFFFFFFF;
        da    = 28'hFFFFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_busy_before got %b want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || wren !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_abort got busy=%b wr=%b want 0",
                     busy, wren);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (wren) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_no_pulse got %b want 0", seen);
        end
        do_op(28'h8000000, 28'h8000000, r, st, edges);
        tests++;
        if (r !== 30'h10000000 || st !== 1'b0 || edges !== 8) begin
            fails++;
            $display("FAIL rstmid_next got %h/%b/%0d want 10000000/0/8",
                     r, st, edges);
        end
        @(negedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        en    = 1'b1;
        sa    = '0;
        da    = '0;
        start = 1'b0;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_start_mid_mul();
        test_clock_enable();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
